// File: rtl/mux_pipe_stage.sv
// rtl/mux_pipe_stage.sv - N:1 select stage with registered output and 2-entry skid buffer
module mux_pipe_stage #(
   parameter int               WIDTH       = 5,
   parameter int               NUM_IN      = 3,
   parameter int               SEL_W       = 2,
   parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              err_count
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   // One extra bit so NUM_IN == 2**SEL_W is representable in the range compare
   localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

   state_t             state;
   logic [WIDTH-1:0]   skid_data;
   logic [SEL_W-1:0]   skid_sel;
   logic               skid_err;
   logic [WIDTH-1:0]   sel_data;
   logic               sel_err;
   logic               push;
   logic               pop;

   // Ready depends only on registered state, never on out_ready
   assign in_ready  = rst_n & (state != TWO);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Select the input word; out-of-range selects forward the default and flag an error
   always_comb begin
      sel_data = DEFAULT_VAL;
      sel_err  = 1'b1;
      if ({1'b0, in_sel} < NUM_IN_L) begin
         sel_err = 1'b0;
         for (int i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
               sel_data = in_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Occupancy FSM: main register drives the outputs, skid absorbs one beat under backpressure
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_data  <= '0;
         out_sel   <= '0;
         out_err   <= 1'b0;
         skid_data <= '0;
         skid_sel  <= '0;
         skid_err  <= 1'b0;
         err_count <= 8'd0;
      end else begin
         // Error beats are counted at acceptance, even if a flush discards them
         if (push && sel_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
         if (flush) begin
            state <= EMPTY;
         end else begin
            case (state)
               EMPTY: begin
                  if (push) begin
                     out_data <= sel_data;
                     out_sel  <= in_sel;
                     out_err  <= sel_err;
                     state    <= ONE;
                  end
               end
               ONE: begin
                  if (push && pop) begin
                     out_data <= sel_data;
                     out_sel  <= in_sel;
                     out_err  <= sel_err;
                  end else if (push) begin
                     skid_data <= sel_data;
                     skid_sel  <= in_sel;
                     skid_err  <= sel_err;
                     state     <= TWO;
                  end else if (pop) begin
                     state <= EMPTY;
                  end
               end
               TWO: begin
                  if (pop) begin
                     out_data <= skid_data;
                     out_sel  <= skid_sel;
                     out_err  <= skid_err;
                     state    <= ONE;
                  end
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// tb/tb_mux_pipe_stage.sv - self-checking bench for mux_pipe_stage
module tb_mux_pipe_stage;

   localparam int WIDTH  = 5;
   localparam int NUM_IN = 3;
   localparam int SEL_W  = 2;

   logic                    clk;
   logic                    rst_n;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;
   logic [7:0]              err_count;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: FIFO of beats {err, sel, data}, capacity 2
   logic [7:0] q[$];
   logic [7:0] hold;
   int         m_err;

   mux_pipe_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEFAULT_VAL(5'd0)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
      .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] make_beat(input logic [14:0] d, input logic [1:0] s);
      int v;
      if (int'(s) < NUM_IN) begin
         v = (int'(d) >> (int'(s) * WIDTH)) % 32;
         return {1'b0, s, v[4:0]};
      end
      return {1'b1, s, 5'd0};
   endfunction

   task automatic model_edge();
      bit do_push, do_pop;
      if (!rst_n) begin
         q.delete();
         m_err = 0;
         hold  = 8'd0;
      end else begin
         do_push = in_valid && (q.size() < 2);
         do_pop  = (q.size() > 0) && out_ready;
         if (do_push && (int'(in_sel) >= NUM_IN) && (m_err < 255)) m_err++;
         if (flush) begin
            q.delete();
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(make_beat(in_data, in_sel));
         end
         if (q.size() > 0) hold = q[0];
      end
   endtask

   task automatic check_all();
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (rst_n && q.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("out_data",  {27'd0, out_data},  {27'd0, hold[4:0]});
      chk("out_sel",   {30'd0, out_sel},   {30'd0, hold[6:5]});
      chk("out_err",   {31'd0, out_err},   {31'd0, hold[7]});
      chk("err_count", {24'd0, err_count}, m_err);
   endtask

   // drive at negedge, update model at posedge, check at next negedge
   task automatic cycle(input logic rn, input logic v, input logic [14:0] d,
                        input logic [1:0] s, input logic ordy, input logic fl);
      rst_n = rn; in_valid = v; in_data = d; in_sel = s; out_ready = ordy; flush = fl;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   localparam logic [14:0] D = {5'd31, 5'd12, 5'd7};

   initial begin
      m_err = 0; hold = 8'd0;
      rst_n = 1'b0; in_valid = 1'b1; in_data = D; in_sel = 2'd0; out_ready = 1'b0; flush = 1'b0;

      // reset with in_valid high
      cycle(0, 1, D, 0, 0, 0);
      cycle(0, 1, D, 0, 0, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      chk("rst_out_data", {27'd0, out_data}, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      chk("rel_in_ready", {31'd0, in_ready}, 1);

      // streaming
      cycle(1, 1, D, 0, 1, 0);
      chk("stream0", {27'd0, out_data}, 7);
      cycle(1, 1, D, 1, 1, 0);
      chk("stream1", {27'd0, out_data}, 12);
      cycle(1, 1, D, 2, 1, 0);
      chk("stream2", {27'd0, out_data}, 31);
      chk("stream_rdy", {31'd0, in_ready}, 1);
      cycle(1, 0, D, 0, 1, 0);

      // backpressure into TWO, then drain
      cycle(1, 1, D, 1, 0, 0);
      cycle(1, 1, D, 0, 0, 0);
      chk("bp_rdy", {31'd0, in_ready}, 0);
      chk("bp_hold", {27'd0, out_data}, 12);
      cycle(1, 1, D, 2, 0, 0);
      chk("bp_hold2", {27'd0, out_data}, 12);
      cycle(1, 0, D, 0, 1, 0);
      chk("bp_drain0", {27'd0, out_data}, 7);
      cycle(1, 0, D, 0, 1, 0);
      chk("bp_empty", {31'd0, out_valid}, 0);

      // out-of-range select and saturation
      cycle(1, 1, D, 3, 1, 0);
      chk("oor_err", {31'd0, out_err}, 1);
      chk("oor_cnt", {24'd0, err_count}, 1);
      for (int i = 0; i < 300; i++) cycle(1, 1, D, 3, 1, 0);
      chk("oor_sat", {24'd0, err_count}, 255);
      cycle(1, 0, D, 0, 1, 0);

      // flush from TWO with a concurrent push
      cycle(1, 1, D, 0, 0, 0);
      cycle(1, 1, D, 1, 0, 0);
      cycle(1, 1, D, 2, 0, 1);
      cycle(1, 1, D, 2, 0, 1);
      chk("flush_valid", {31'd0, out_valid}, 0);
      chk("flush_rdy", {31'd0, in_ready}, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, D, 0, 1, 0);

      // mid-operation reset from TWO with err_count = 4
      cycle(0, 0, D, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 1, D, 3, 1, 0);
      cycle(1, 0, D, 0, 1, 0);
      cycle(1, 1, D, 0, 0, 0);
      cycle(1, 1, D, 1, 0, 0);
      chk("mid_cnt4", {24'd0, err_count}, 4);
      cycle(0, 0, D, 0, 0, 0);
      chk("mid_cnt0", {24'd0, err_count}, 0);
      chk("mid_valid", {31'd0, out_valid}, 0);
      chk("mid_data", {27'd0, out_data}, 0);
      cycle(1, 1, D, 2, 0, 0);
      chk("mid_lat", {27'd0, out_data}, 31);
      chk("mid_lat_v", {31'd0, out_valid}, 1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), 15'($urandom),
               2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
